// File: rtl/mips_pkg.sv
`default_nettype none
// mips_pkg: opcode/funct constants, ALU and PC-control encodings, FSM states for the MIPS-subset core.
// Revision 1.0
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;

  localparam logic [3:0] PC_HOLD   = 4'd0;
  localparam logic [3:0] PC_INC    = 4'd1;
  localparam logic [3:0] PC_JUMP   = 4'd2;
  localparam logic [3:0] PC_BRANCH = 4'd3;
  localparam logic [3:0] PC_REG    = 4'd4;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE = 3'd0,
    CLS_ADDI  = 3'd1,
    CLS_LW    = 3'd2,
    CLS_SW    = 3'd3,
    CLS_BEQ   = 3'd4,
    CLS_JR    = 3'd5,
    CLS_J     = 3'd6
  } op_class_t;

endpackage
`default_nettype wire

// File: rtl/mips_alu_decode.sv
`default_nettype none
// mips_alu_decode: combinational opcode/funct classifier producing ALU op, operand select and legality.
// Revision 1.0
module mips_alu_decode
  import mips_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  output logic [ALU_CTRL_W-1:0] alu_op,
  output logic                  alu_src,
  output op_class_t             op_class,
  output logic                  legal
);

  always_comb begin
    alu_op   = ALU_CTRL_W'(ALU_ADD);
    alu_src  = 1'b0;
    op_class = CLS_RTYPE;
    legal    = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_op = ALU_CTRL_W'(ALU_ADD);
          FN_SUB:  alu_op = ALU_CTRL_W'(ALU_SUB);
          FN_AND:  alu_op = ALU_CTRL_W'(ALU_AND);
          FN_OR:   alu_op = ALU_CTRL_W'(ALU_OR);
          FN_SLT:  alu_op = ALU_CTRL_W'(ALU_SLT);
          FN_JR:   op_class = CLS_JR;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        op_class = CLS_ADDI;
        alu_src  = 1'b1;
      end
      OP_LW: begin
        op_class = CLS_LW;
        alu_src  = 1'b1;
      end
      OP_SW: begin
        op_class = CLS_SW;
        alu_src  = 1'b1;
      end
      OP_BEQ: begin
        op_class = CLS_BEQ;
        alu_op   = ALU_CTRL_W'(ALU_SUB);
      end
      OP_J:    op_class = CLS_J;
      default: legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_mc_sequencer.sv
`default_nettype none
// mips_mc_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK control FSM with handshaked memories.
// Optional memory-ack watchdog enabled by MC_SEQ_TIMEOUT_EN. Revision 1.0
module mips_mc_sequencer
  import mips_pkg::*;
#(
  parameter int PC_CTRL_W      = 4,
  parameter int ALU_CTRL_W     = 4,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instruction,
  input  logic                  imem_ack,
  input  logic                  dmem_ack,
  input  logic                  alu_zero,
  output logic                  imem_req,
  output logic                  ir_load,
  output logic                  dmem_req,
  output logic                  data_mem_wren,
  output logic                  reg_file_wren,
  output logic                  reg_file_dmux_select,
  output logic                  reg_file_rmux_select,
  output logic                  alu_mux_select,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [PC_CTRL_W-1:0]  pc_control,
  output logic                  illegal,
  output logic [CNT_W-1:0]      retired_count
);

  state_t                  state;
  op_class_t               cls_q;
  logic [ALU_CTRL_W-1:0]   alu_op_q;
  logic                    alu_src_q;

  logic [ALU_CTRL_W-1:0]   dec_alu_op;
  logic                    dec_alu_src;
  op_class_t               dec_class;
  logic                    dec_legal;
  logic                    timeout;
  logic                    unused_instr_bits;

  assign unused_instr_bits = ^instruction[25:6];

  mips_alu_decode #(
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_decode (
    .opcode   (instruction[31:26]),
    .funct    (instruction[5:0]),
    .alu_op   (dec_alu_op),
    .alu_src  (dec_alu_src),
    .op_class (dec_class),
    .legal    (dec_legal)
  );

`ifdef MC_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt;
  logic            waiting;

  assign waiting = (state == S_FETCH && !imem_ack) || (state == S_MEM && !dmem_ack);
  assign timeout = waiting && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wait_cnt <= '0;
    else if (waiting && !timeout)
      wait_cnt <= wait_cnt + TO_W'(1);
    else
      wait_cnt <= '0;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Requests are masked while reset is held so nothing is issued from the reset state.
  always_comb begin
    imem_req             = 1'b0;
    ir_load              = 1'b0;
    dmem_req             = 1'b0;
    data_mem_wren        = 1'b0;
    reg_file_wren        = 1'b0;
    reg_file_dmux_select = 1'b0;
    reg_file_rmux_select = 1'b0;
    alu_mux_select       = 1'b0;
    alu_control          = '0;
    pc_control           = PC_CTRL_W'(PC_HOLD);
    case (state)
      S_FETCH: begin
        imem_req = rst;
        ir_load  = rst & imem_ack;
      end
      S_DECODE: begin
        if (dec_legal && dec_class == CLS_J)
          pc_control = PC_CTRL_W'(PC_JUMP);
      end
      S_EXECUTE: begin
        alu_control    = alu_op_q;
        alu_mux_select = alu_src_q;
        if (cls_q == CLS_BEQ)
          pc_control = alu_zero ? PC_CTRL_W'(PC_BRANCH) : PC_CTRL_W'(PC_INC);
        else if (cls_q == CLS_JR)
          pc_control = PC_CTRL_W'(PC_REG);
      end
      S_MEM: begin
        alu_control    = alu_op_q;
        alu_mux_select = alu_src_q;
        dmem_req       = 1'b1;
        data_mem_wren  = (cls_q == CLS_SW);
        if (cls_q == CLS_SW && dmem_ack)
          pc_control = PC_CTRL_W'(PC_INC);
      end
      S_WRITEBACK: begin
        alu_control          = alu_op_q;
        alu_mux_select       = alu_src_q;
        reg_file_wren        = 1'b1;
        reg_file_dmux_select = (cls_q == CLS_LW);
        reg_file_rmux_select = (cls_q == CLS_RTYPE);
        pc_control           = PC_CTRL_W'(PC_INC);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_FETCH;
      cls_q         <= CLS_RTYPE;
      alu_op_q      <= '0;
      alu_src_q     <= 1'b0;
      illegal       <= 1'b0;
      retired_count <= '0;
    end else begin
      if (pc_control != '0)
        retired_count <= retired_count + CNT_W'(1);
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            state <= S_DECODE;
          end else if (timeout) begin
            state   <= S_TRAP;
            illegal <= 1'b1;
          end
        end
        S_DECODE: begin
          if (!dec_legal) begin
            state   <= S_TRAP;
            illegal <= 1'b1;
          end else begin
            cls_q     <= dec_class;
            alu_op_q  <= dec_alu_op;
            alu_src_q <= dec_alu_src;
            state     <= (dec_class == CLS_J) ? S_FETCH : S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          case (cls_q)
            CLS_BEQ, CLS_JR: state <= S_FETCH;
            CLS_LW, CLS_SW:  state <= S_MEM;
            default:         state <= S_WRITEBACK;
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            state <= (cls_q == CLS_LW) ? S_WRITEBACK : S_FETCH;
          end else if (timeout) begin
            state   <= S_TRAP;
            illegal <= 1'b1;
          end
        end
        S_WRITEBACK: state <= S_FETCH;
        S_TRAP:      state <= S_TRAP;
        default:     state <= S_FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mips_mc_sequencer.md
# mips_mc_sequencer

Multi-cycle control sequencer for the MIPS-subset CPU. It replaces the single-cycle combinational control unit with an FSM that splits each instruction into FETCH/DECODE/EXECUTE/MEM/WRITEBACK steps. It adds handshaked instruction and data memory accesses, so the core tolerates multi-cycle memories. It sits between the instruction register, register file, ALU, data memory and program counter in the CPU top level, and drives all their enables and mux selects.

## Interface
- PC_CTRL_W, 4, width of pc_control
- ALU_CTRL_W, 4, width of alu_control
- CNT_W, 32, width of retired-instruction counter
- TIMEOUT_CYCLES, 16, memory-ack watchdog limit (used only with MC_SEQ_TIMEOUT_EN)
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- instruction  in  32  instruction register contents
- imem_ack  in  1  instruction memory data valid
- dmem_ack  in  1  data memory access complete
- alu_zero  in  1  ALU zero flag
- imem_req  out  1  instruction fetch request
- ir_load  out  1  load instruction register
- dmem_req  out  1  data memory request
- data_mem_wren  out  1  data memory write
- reg_file_wren  out  1  register file write
- reg_file_dmux_select  out  1  write data: 0 ALU result, 1 memory read data
- reg_file_rmux_select  out  1  write address: 0 rt, 1 rd
- alu_mux_select  out  1  operand1: 0 rdata1, 1 sign-extended immediate
- alu_control  out  ALU_CTRL_W  ALU operation
- pc_control  out  PC_CTRL_W  0 hold, 1 +4, 2 jump, 3 branch, 4 register
- illegal  out  1  sticky illegal-opcode flag
- retired_count  out  CNT_W  instructions completed

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- FETCH: hold imem_req=1 until imem_ack. On the ack cycle, pulse ir_load and go to DECODE.
- DECODE: one cycle. Classify opcode instruction[31:26]:
  - R-type 0x00, addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
  - R-type funct 0x08 (jr) is legal.
  - Any other opcode or funct -> TRAP with illegal=1.
- j: in DECODE, pc_control=2 and go to FETCH.
- EXECUTE: alu_control is set from decode.
  - funct 0x20 ADD=2, 0x22 SUB=6, 0x24 AND=0, 0x25 OR=1, 0x2A SLT=7.
  - addi/lw/sw use ADD with alu_mux_select=1. beq uses SUB.
  - beq: pc_control=3 if alu_zero, else 1. Then go to FETCH.
  - jr: pc_control=4, then go to FETCH.
  - lw/sw go to MEM. R-type and addi go to WRITEBACK.
- MEM: hold dmem_req=1 until dmem_ack. For sw, data_mem_wren=1 for the same cycles.
  - sw: on ack, pc_control=1 and go to FETCH.
  - lw: on ack, go to WRITEBACK.
- WRITEBACK: reg_file_wren=1 for one cycle, pc_control=1, go to FETCH.
  - lw: dmux=1, rmux=0. addi: dmux=0, rmux=0. R-type: dmux=0, rmux=1.
- retired_count increments on each cycle where pc_control≠0. It wraps modulo 2^CNT_W.
- TRAP: all enables are 0 and pc_control=0. The block stays in TRAP until reset.

## Timing
- Reset (rst=0, async): state=FETCH and retired_count=0. All outputs are 0 (illegal=0, pc_control=0, alu_control=0, all selects 0).
- All control outputs are registered-state decodes (Moore), except:
  - ir_load, which depends on imem_ack in the same cycle;
  - MEM exit, which depends on dmem_ack;
  - beq pc_control, which depends on alu_zero.
- Minimum cycles with ack in the first request cycle:
  - j = 2
  - beq / jr = 3
  - R-type / addi / sw = 4
  - lw = 5
- Each cycle of ack delay adds exactly one cycle.
- An ack arriving while req=0 is ignored.
- Reset mid-instruction abandons the instruction with no writes and no PC update.

## Configuration
- MC_SEQ_TIMEOUT_EN defined: a counter runs during FETCH and MEM waits. If the wait reaches TIMEOUT_CYCLES cycles without ack, the block enters TRAP and sets illegal=1.
- Not defined: the block waits indefinitely and the counter logic is absent.

## Structure
- Shared package mips_pkg holds:
  - opcode/funct constants;
  - ALU op encodings (ADD/SUB/AND/OR/SLT);
  - pc_control encodings;
  - the state enum.
- Natural sub-module: mips_alu_decode, combinational funct/opcode -> alu_control and legality.

## Test plan
- Reset, then add (op 0x00, funct 0x20) with imem_ack and dmem_ack tied high:
  - FETCH→DECODE→EXECUTE→WRITEBACK, alu_control=2, rmux=1, one reg_file_wren pulse.
  - retired_count=1 after 4 cycles.
- lw with dmem_ack delayed 3 cycles:
  - dmem_req high for 4 cycles, then WRITEBACK with dmux=1.
  - Instruction takes 8 cycles total.
- beq with alu_zero=1:
  - pc_control=3 in EXECUTE.
  - Repeat with alu_zero=0: pc_control=1.
- Opcode 0x3F:
  - TRAP after DECODE, illegal=1, pc_control stays 0 for 20 cycles.
  - rst low clears illegal asynchronously.
- retired_count preloaded near wrap (CNT_W=4, 15 instructions executed): the 16th instruction returns it to 0.
- With MC_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, imem_ack held low: TRAP and illegal=1 after 16 cycles.
